icb_sram_responder: RTL and testbench

//  ICB slave (responder) for the accelerator's memory-side ICB master port (acc_icb_*).

---
 rtl/icb_pkg.sv | 17 +
 rtl/icb_rsp_fifo.sv | 54 +++++
 rtl/icb_sram_responder.sv | 147 ++++++++++++++
 tb/tb_icb_sram_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_pkg.sv
// Shared ICB definitions used by every ICB slave in this design.
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;

    typedef struct packed {
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } icb_rsp_t;

    typedef enum logic {
        ICB_WRITE = 1'b0,
        ICB_READ  = 1'b1
    } icb_op_e;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous response FIFO of icb_rsp_t; DEPTH must be a power of two.
module icb_rsp_fifo
    import icb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  icb_rsp_t                 push_data,
    input  logic                     pop,
    output icb_rsp_t                 pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    icb_rsp_t       store [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign pop_data = store[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (rst_n) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst_n) !(pop && empty));
`endif

endmodule

// File: rtl/icb_sram_responder.sv
// ICB slave backed by a word-addressed SRAM with in-order, backpressured responses.
// Optional ICB_RSP_STALL_EN adds LFSR-driven cmd/rsp stalls for stress testing.
module icb_sram_responder
    import icb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 4096,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         icb_cmd_valid,
    output logic                         icb_cmd_ready,
    input  logic                         icb_cmd_read,
    input  logic [AW-1:0]                icb_cmd_addr,
    input  logic [DW-1:0]                icb_cmd_wdata,
    input  logic [DW/8-1:0]              icb_cmd_wmask,
    output logic                         icb_rsp_valid,
    input  logic                         icb_rsp_ready,
    output logic [DW-1:0]                icb_rsp_rdata,
    output logic                         icb_rsp_err,
    output logic [$clog2(RSP_DEPTH):0]   outstanding
);

    localparam int MW = DW / 8;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [DW-1:0]  mem [MEM_WORDS];

    logic           cmd_fire;
    logic           rsp_fire;
    logic           addr_ok;
    logic [IW-1:0]  word_idx;
    icb_op_e        op;

    logic           stg_vld_p1;
    icb_rsp_t       stg_rsp_p1;

    icb_rsp_t       fifo_head;
    icb_rsp_t       rsp_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           fifo_push;
    logic           fifo_pop;
    logic           bypass;
    logic           rsp_avail;

    logic           stall_cmd;
    logic           stall_rsp;
    logic [CW-1:0]  outstanding_q;

    assign op       = icb_op_e'(icb_cmd_read);
    assign addr_ok  = (icb_cmd_addr[1:0] == 2'b00) && ((icb_cmd_addr >> 2) < AW'(MEM_WORDS));
    assign word_idx = icb_cmd_addr[IW+1:2];

    // Ready is a function of the registered count only; held low while reset is asserted.
    assign icb_cmd_ready = !rst_n && (outstanding_q < CW'(RSP_DEPTH)) && !stall_cmd;
    assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;

    always_ff @(posedge clk) begin
        if (cmd_fire && addr_ok && op == ICB_WRITE) begin
            for (int b = 0; b < MW; b++) begin
                if (icb_cmd_wmask[b]) mem[word_idx][b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
            end
        end
    end

    // Stage p1: SRAM read data and error flag for the command accepted last cycle
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) stg_vld_p1 <= 1'b0;
        else       stg_vld_p1 <= cmd_fire;
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            stg_rsp_p1.err   <= !addr_ok;
            stg_rsp_p1.rdata <= (addr_ok && op == ICB_READ) ? mem[word_idx] : '0;
        end
    end

    // Response side: FIFO head, or the stage itself when the FIFO is empty
    assign rsp_avail     = !fifo_empty || stg_vld_p1;
    assign rsp_head      = fifo_empty ? stg_rsp_p1 : fifo_head;
    assign icb_rsp_valid = rsp_avail && !stall_rsp;
    assign icb_rsp_rdata = icb_rsp_valid ? rsp_head.rdata : '0;
    assign icb_rsp_err   = icb_rsp_valid ? rsp_head.err   : 1'b0;
    assign rsp_fire      = icb_rsp_valid && icb_rsp_ready;

    // A stage entry consumed straight through the bypass never enters the FIFO.
    assign bypass    = fifo_empty && stg_vld_p1;
    assign fifo_push = stg_vld_p1 && !(bypass && rsp_fire);
    assign fifo_pop  = rsp_fire && !fifo_empty;

    icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (stg_rsp_p1),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            outstanding_q <= '0;
        end else begin
            unique case ({cmd_fire, rsp_fire})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign outstanding = outstanding_q;

`ifdef ICB_RSP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall_cmd = (lfsr_q[1:0] == 2'b00);
    assign stall_rsp = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_cmd = 1'b0;
    assign stall_rsp = 1'b0;
`endif

`ifndef SYNTHESIS
    a_out_max:   assert property (@(posedge clk) disable iff (rst_n) outstanding_q <= CW'(RSP_DEPTH));
    a_out_track: assert property (@(posedge clk) disable iff (rst_n)
                                  outstanding_q == fifo_count + CW'(stg_vld_p1));
    a_fifo_room: assert property (@(posedge clk) disable iff (rst_n) !(fifo_push && fifo_full));
`endif

endmodule

// File: tb/tb_icb_sram_responder.sv
// Randomized bench for icb_sram_responder with a queue/array reference model.
module tb_icb_sram_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4096;
    localparam int RD = 4;
    localparam int CW = $clog2(RD) + 1;
    localparam int IW = $clog2(MW);

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_s;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            icb_cmd_valid = 1'b0;
    logic            icb_cmd_ready;
    logic            icb_cmd_read = 1'b0;
    logic [AW-1:0]   icb_cmd_addr = '0;
    logic [DW-1:0]   icb_cmd_wdata = '0;
    logic [DW/8-1:0] icb_cmd_wmask = '0;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready = 1'b0;
    logic [DW-1:0]   icb_rsp_rdata;
    logic            icb_rsp_err;
    logic [CW-1:0]   outstanding;

    logic [DW-1:0]   ref_mem [MW];
    rsp_s            pend_q[$];
    rsp_s            exp_q[$];
    rsp_s            act_q[$];
    int              act_cyc[$];
    int              cyc = 0;
    int              pass_cnt = 0;
    int              total_cnt = 0;
    logic            rsp_rdy = 1'b0;

    icb_sram_responder #(
        .AW(AW), .DW(DW), .MEM_WORDS(MW), .RSP_DEPTH(RD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .outstanding   (outstanding)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs, log handshakes, update the model, step past the edge.
    task automatic tick(input logic v, input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW/8-1:0] wm, output logic acc);
        rsp_s          e;
        logic [IW-1:0] idx;
        icb_cmd_valid = v;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        icb_rsp_ready = rsp_rdy;
        acc = v && icb_cmd_ready;
        if (icb_rsp_valid && rsp_rdy) begin
            act_q.push_back({icb_rsp_err, icb_rsp_rdata});
            act_cyc.push_back(cyc);
            if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            else                   exp_q.push_back({1'bx, {DW{1'bx}}});
        end
        if (acc) begin
            idx = a[IW+1:2];
            if (a % 4 != 0 || a / 4 >= MW) begin
                e = {1'b1, {DW{1'b0}}};
            end else if (rd) begin
                e = {1'b0, ref_mem[idx]};
            end else begin
                for (int b = 0; b < DW/8; b++)
                    if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                e = {1'b0, {DW{1'b0}}};
            end
            pend_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] wm, output int acc_cyc);
        logic acc;
        acc = 1'b0;
        acc_cyc = -1;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc_cyc = cyc;
            tick(1'b1, rd, a, wd, wm, acc);
        end
        if (!acc) acc_cyc = -1;
    endtask

    task automatic drain(output bit ok);
        logic acc;
        rsp_rdy = 1'b1;
        for (int t = 0; t < 100 && pend_q.size() > 0; t++) tick(1'b0, 1'b0, '0, '0, '0, acc);
        ok = (pend_q.size() == 0);
    endtask

    task automatic clear_logs();
        act_q.delete();
        exp_q.delete();
        act_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        rsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, outstanding} !== '0)
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b out=%0d, required all 0",
                     icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, outstanding);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (icb_cmd_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b required 1", icb_cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        int c;
        bit ok;
        clear_logs();
        rsp_rdy = 1'b1;
        issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, c);
        issue(1'b1, 32'h10, '0, '0, c);
        drain(ok);
        total_cnt++;
        if (!ok || act_q.size() != 2) $display("FAIL wr_rd_count: got %0d rsps required 2", act_q.size());
        else pass_cnt++;
        foreach (act_q[i]) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL wr_rd_rsp%0d: got %h required %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (act_q.size() < 2 || act_q[1] !== {1'b0, 32'hDEADBEEF})
            $display("FAIL wr_rd_value: got %h required 0deadbeef", act_q.size() < 2 ? '0 : act_q[1]);
        else pass_cnt++;
    endtask

    task automatic test_byte_mask();
        int c;
        bit ok;
        clear_logs();
        rsp_rdy = 1'b1;
        issue(1'b0, 32'h20, 32'h11223344, 4'hF, c);
        issue(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, c);
        issue(1'b1, 32'h20, '0, '0, c);
        drain(ok);
        total_cnt++;
        if (!ok || act_q.size() != 3) $display("FAIL mask_count: got %0d rsps required 3", act_q.size());
        else pass_cnt++;
        foreach (act_q[i]) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL mask_rsp%0d: got %h required %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (act_q.size() < 3 || act_q[2].rdata !== 32'h11BB33DD)
            $display("FAIL mask_value: got %h required 11bb33dd", act_q.size() < 3 ? '0 : act_q[2].rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        bit ok;
        clear_logs();
        rsp_rdy = 1'b1;
        issue(1'b0, 32'h40, 32'h5, 4'hF, c0);
        issue(1'b1, 32'h40, '0, '0, c1);
        drain(ok);
        total_cnt++;
        if (!ok || act_q.size() != 2 || c1 != c0 + 1)
            $display("FAIL b2b_accept: got rsps=%0d gap=%0d required 2 and 1", act_q.size(), c1 - c0);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() < 2 || act_cyc[0] != c0 + 1 || act_cyc[1] != c0 + 2)
            $display("FAIL b2b_latency: got %0d,%0d required 1,2", act_q.size() < 2 ? -1 : act_cyc[0] - c0,
                     act_q.size() < 2 ? -1 : act_cyc[1] - c0);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() < 2 || act_q[1] !== {1'b0, 32'h5})
            $display("FAIL b2b_value: got %h required 5", act_q.size() < 2 ? '0 : act_q[1]);
        else pass_cnt++;
    endtask

    task automatic test_addr_error();
        int c;
        bit ok;
        clear_logs();
        rsp_rdy = 1'b1;
        issue(1'b0, 32'h0, 32'hCAFEF00D, 4'hF, c);
        issue(1'b1, 32'h4002, '0, '0, c);
        issue(1'b1, MW * 4, '0, '0, c);
        issue(1'b0, MW * 4, 32'h0, 4'hF, c);
        issue(1'b0, 32'h12, 32'h0, 4'hF, c);
        issue(1'b1, 32'h0, '0, '0, c);
        issue(1'b1, 32'h10, '0, '0, c);
        drain(ok);
        total_cnt++;
        if (!ok || act_q.size() != 7) $display("FAIL err_count: got %0d rsps required 7", act_q.size());
        else pass_cnt++;
        foreach (act_q[i]) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL err_rsp%0d: got %h required %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (act_q.size() < 7 || act_q[1] !== {1'b1, 32'h0} || act_q[2] !== {1'b1, 32'h0}
            || act_q[5] !== {1'b0, 32'hCAFEF00D} || act_q[6] !== {1'b0, 32'hDEADBEEF})
            $display("FAIL err_values: got rsps=%0d, required err reads and unchanged 0x0/0x10", act_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int c;
        int issued;
        bit ok;
        logic acc;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) issue(1'b0, 32'h100 + 4 * i, $urandom, 4'hF, c);
        drain(ok);
        clear_logs();
        rsp_rdy = 1'b0;
        issued = 0;
        for (int t = 0; t < 60 && (issued < 6 || pend_q.size() > 0); t++) begin
            if (t == 8) begin
                total_cnt++;
                if (issued != 4 || icb_cmd_ready !== 1'b0 || outstanding !== CW'(4))
                    $display("FAIL bp_full: got issued=%0d ready=%b out=%0d required 4,0,4",
                             issued, icb_cmd_ready, outstanding);
                else pass_cnt++;
                rsp_rdy = 1'b1;
            end
            total_cnt++;
            if (icb_cmd_ready !== (pend_q.size() < RD))
                $display("FAIL bp_ready_t%0d: got %b required %b", t, icb_cmd_ready, pend_q.size() < RD);
            else pass_cnt++;
            tick(issued < 6, 1'b1, 32'h100 + 4 * issued, '0, '0, acc);
            if (acc) issued++;
        end
        total_cnt++;
        if (act_q.size() != 6) $display("FAIL bp_count: got %0d rsps required 6", act_q.size());
        else pass_cnt++;
        foreach (act_q[i]) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL bp_rsp%0d: got %h required %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop();
        int c;
        bit ok;
        clear_logs();
        rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'h10, '0, '0, c);
        icb_cmd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (icb_rsp_valid !== 1'b0 || outstanding !== '0 || icb_cmd_ready !== 1'b0)
            $display("FAIL midop_reset: got valid=%b out=%0d ready=%b required 0,0,0",
                     icb_rsp_valid, outstanding, icb_cmd_ready);
        else pass_cnt++;
        pend_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        rsp_rdy = 1'b1;
        issue(1'b1, 32'h10, '0, '0, c);
        drain(ok);
        total_cnt++;
        if (!ok || act_q.size() != 1 || act_q[0] !== {1'b0, 32'hDEADBEEF})
            $display("FAIL midop_retain: got rsps=%0d data=%h required 1 and deadbeef",
                     act_q.size(), act_q.size() > 0 ? act_q[0] : '0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int c;
        int issued;
        bit ok;
        logic acc;
        logic [AW-1:0] a;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) issue(1'b0, 32'h200 + 4 * i, $urandom, 4'hF, c);
        drain(ok);
        clear_logs();
        issued = 0;
        for (int t = 0; t < 3000 && (issued < 200 || pend_q.size() > 0); t++) begin
            total_cnt++;
            if (outstanding !== CW'(pend_q.size()))
                $display("FAIL rnd_outstanding_t%0d: got %0d required %0d", t, outstanding, pend_q.size());
            else pass_cnt++;
`ifndef ICB_RSP_STALL_EN
            total_cnt++;
            if ({icb_cmd_ready, icb_rsp_valid} !== {pend_q.size() < RD, pend_q.size() > 0})
                $display("FAIL rnd_flags_t%0d: got ready=%b valid=%b required %b,%b", t, icb_cmd_ready,
                         icb_rsp_valid, pend_q.size() < RD, pend_q.size() > 0);
            else pass_cnt++;
`endif
            rsp_rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 15))
                0:       a = 32'h4000 + 4 * $urandom_range(0, 3);
                1:       a = 32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                default: a = 32'h200 + 4 * $urandom_range(0, 15);
            endcase
            tick(issued < 200 && $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom), acc);
            if (acc) issued++;
        end
        total_cnt++;
        if (issued != 200 || pend_q.size() != 0 || act_q.size() != 200)
            $display("FAIL rnd_complete: got issued=%0d pending=%0d rsps=%0d required 200,0,200",
                     issued, pend_q.size(), act_q.size());
        else pass_cnt++;
        foreach (act_q[i]) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i]) $display("FAIL rnd_rsp%0d: got %h required %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
`ifndef ICB_RSP_STALL_EN
        test_byte_mask();
        test_back_to_back();
        test_addr_error();
        test_backpressure();
        test_reset_midop();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
